// File: rtl/farm_cam_pkg.sv
// Shared definitions for the camera frame transmitter: RGB332 colours,
// test-pattern encodings, frame FSM states and a small sizing helper.
package farm_cam_pkg;

    // RGB332 colours, {R[7:5], G[4:2], B[1:0]}
    localparam logic [7:0] COL_GREEN = 8'h1C;
    localparam logic [7:0] COL_RED   = 8'hE0;
    localparam logic [7:0] COL_BLUE  = 8'h03;
    localparam logic [7:0] COL_WHITE = 8'hFF;

    // pat_sel encodings
    localparam logic [1:0] PAT_STREAM = 2'd0;
    localparam logic [1:0] PAT_GREEN  = 2'd1;
    localparam logic [1:0] PAT_RED    = 2'd2;
    localparam logic [1:0] PAT_BARS   = 2'd3;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4,
        ST_DONE   = 3'd5
    } cam_state_e;

    // Largest of four timing lengths; sizes the shared phase counter.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// 4-entry x 8-bit synchronous FIFO for the incoming pixel stream.
// Push into a full FIFO and pop from an empty FIFO are ignored, so the
// caller may present raw requests; status flags come straight from the
// occupancy counter.
module pix_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (count_q == 3'd4);
    assign empty_o = (count_q == 3'd0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers and occupancy; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cam_frame_tx.sv
// Camera-side frame generator: vsync pulse, href-framed lines and RGB332
// pixel bytes, sourced either from a valid/ready stream (via pix_fifo) or
// from a built-in pattern. All frame outputs are registered together so
// they stay cycle-aligned; they are computed from the next state so that
// a state entered on an edge is visible on the outputs in that same cycle.
module cam_frame_tx
    import farm_cam_pkg::*;
#(
    parameter int H_ACTIVE  = 64,
    parameter int H_BLANK   = 16,
    parameter int V_ACTIVE  = 48,
    parameter int V_BLANK   = 4,
    parameter int VSYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] pat_sel,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       vsync,
    output logic       href,
    output logic [7:0] pixel,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic [7:0] frame_cnt
);

    localparam int CNT_W = $clog2(max_of4(H_ACTIVE, H_BLANK, V_BLANK, VSYNC_LEN));
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_LEN - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BLANK - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    localparam logic [CNT_W-1:0] BAR1 = CNT_W'(H_ACTIVE / 4);
    localparam logic [CNT_W-1:0] BAR2 = CNT_W'(H_ACTIVE / 2);
    localparam logic [CNT_W-1:0] BAR3 = CNT_W'((3 * H_ACTIVE) / 4);

    // Sequencer state
    cam_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       pat_q, pat_d;

    // Registered outputs
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic [7:0]       pixel_q, pixel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             stream_pix;

    // Colour-bar lookup by column: four equal-width vertical bars.
    function automatic logic [7:0] bar_pixel(input logic [CNT_W-1:0] col);
        if (col < BAR1)      return COL_GREEN;
        else if (col < BAR2) return COL_RED;
        else if (col < BAR3) return COL_BLUE;
        else                 return COL_WHITE;
    endfunction

    // Ready drops whenever full, even if a pop frees a slot this cycle;
    // this keeps the ready path free of the FSM decode.
    assign pix_ready = ena & ~fifo_full;
    assign fifo_push = pix_valid & pix_ready;
    assign fifo_pop  = ena & stream_pix & ~fifo_empty;

    pix_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (pix_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state, counter reload and output decode for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        pat_d   = pat_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_VSYNC;
                    cnt_d   = '0;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LINE: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = (row_q == ROW_LAST) ? ST_VBLANK : ST_HBLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    row_d   = row_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = continuous ? ST_VSYNC : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pattern is frozen for the frame from the moment vsync starts.
        if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
            pat_d = pat_sel;
        end

        stream_pix = (state_d == ST_LINE) && (pat_d == PAT_STREAM);

        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_LINE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);

        pixel_d = 8'h00;
        if (state_d == ST_LINE) begin
            case (pat_d)
                PAT_STREAM: pixel_d = fifo_empty ? 8'h00 : fifo_rdata;
                PAT_GREEN:  pixel_d = COL_GREEN;
                PAT_RED:    pixel_d = COL_RED;
                default:    pixel_d = bar_pixel(cnt_d);
            endcase
        end

        // A stream pixel with nothing queued is a sticky underrun; timing never stalls.
        underrun_d = underrun_q | (stream_pix & fifo_empty);

        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_VBLANK && state_d == ST_DONE) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Sequencer and output registers; ena low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            pat_q       <= PAT_STREAM;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pixel_q     <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else if (ena) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            pixel_q     <= pixel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign pixel      = pixel_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
